uart_rx: RTL



---
 rtl/uart_rx_if.sv | 12 +
 rtl/uart_rx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART: serial pin in, byte/strobe/status out.
// The master modport is the receiver itself; the slave side drives the pin and consumes bytes.
interface uart_rx_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       led;

    modport master (input rx, output rx_data, rx_valid, frame_err, led);
    modport slave  (output rx, input rx_data, rx_valid, frame_err, led);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, falling-edge start detect, mid-bit sampling.
// Emits one-cycle rx_valid / frame_err strobes and toggles led on every good byte.
module uart_rx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD - 1;
    localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam int CNT_W        = $clog2(BAUD_CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX_C  = CNT_W'(BAUD_CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_HALF_C = CNT_W'(HALF_CNT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rx_s1, rx_s2, rx_d;
    logic [1:0]       fill_q;
    logic             armed_q;
    logic             fall;
    logic             valid_d, ferr_d;
    logic [7:0]       data_q;
    logic             valid_q, ferr_q, led_q;

    // The synchronizer resets to 1, so a line already low at reset release would look
    // like a falling edge. Arm edge detection only once a real high has come through.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b1;
            fill_q  <= 2'b00;
            armed_q <= 1'b0;
        end else begin
            rx_s1  <= bus.rx;
            rx_s2  <= rx_s1;
            rx_d   <= rx_s2;
            fill_q <= {fill_q[0], 1'b1};
            if (fill_q[1] && rx_s2)
                armed_q <= 1'b1;
        end
    end

    assign fall = armed_q && rx_d && !rx_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall)
                    state_d = START;
            end
            START: begin
                if (cnt_q == CNT_HALF_C) begin
                    cnt_d = '0;
                    if (!rx_s2) begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CNT_MAX_C) begin
                    cnt_d              = '0;
                    shreg_d[bit_idx_q] = rx_s2;
                    if (bit_idx_q == 3'd7)
                        state_d = STOP;
                    else
                        bit_idx_d = bit_idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CNT_MAX_C) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    valid_d = rx_s2;
                    ferr_d  = !rx_s2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            led_q   <= 1'b1;
        end else begin
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            if (valid_d) begin
                data_q <= shreg_q;
                led_q  <= ~led_q;
            end
        end
    end

    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.led       = led_q;
endmodule
